ro_trace_acq: RTL and testbench
===============================

Name: ro_trace_acq

Overview:
- Downstream consumer of the ring-oscillator bank.
- Takes each per-sample vector of RO counts, reduces it to one summed sample, and captures a fixed-length trace into on-chip memory after a trigger.
- The AXI-lite register wrapper reads the trace back through a simple synchronous read port.
- Sits between the RO bank count outputs and the AXI slave register file of the sensor IP.

Parameters:
- N_RO, 8, number of ring oscillators in the bank (1..32)
- CNT_W, 16, width of each RO count
- SUM_W, CNT_W+$clog2(N_RO), width of summed sample; never overflows
- DEPTH, 256, trace length in samples (power of two)

Ports:
- clock  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high reset
- start  in  1  1-cycle pulse; arms acquisition
- abort  in  1  1-cycle pulse; returns to IDLE
- trig_in  in  1  level trigger from the target; rising edge starts capture
- ro_valid  in  1  1-cycle pulse; ro_counts holds a new sample
- ro_counts  in  N_RO*CNT_W  packed counts, RO k at bits [k*CNT_W +: CNT_W]
- rd_addr  in  $clog2(DEPTH)  trace read address
- rd_data  out  SUM_W  trace word at rd_addr, 1-cycle latency
- busy  out  1  high in ARMED or CAPTURE
- done  out  1  high in DONE
- wr_ptr  out  $clog2(DEPTH)+1  number of samples captured

Behaviour:
- Async reset values: state=IDLE, busy=0, done=0, wr_ptr=0, trig edge register=0, sum pipeline valid=0, rd_data=0. Trace memory contents are not reset.
- Sum stage:
  - On ro_valid, register sum = zero-extended sum of all N_RO counts.
  - sum_valid asserts the following cycle; latency is 1 clock.
  - ro_valid while sum_valid is high overwrites the registered sum; there is no backpressure.
- Trigger edge: trig_rise = trig_in & ~trig_q, with trig_q registered every cycle.
- States:
  - IDLE: start -> ARMED with wr_ptr cleared to 0.
  - ARMED: trig_rise -> CAPTURE. The sum_valid in the same cycle as trig_rise is NOT stored; storage begins with the next sum_valid.
  - CAPTURE: each sum_valid writes mem[wr_ptr] and increments wr_ptr. When wr_ptr reaches DEPTH -> DONE. trig_in is ignored in this state.
  - DONE: done=1 and wr_ptr=DEPTH hold. start -> ARMED and clears wr_ptr; done drops the next cycle.
- abort in any state -> IDLE next cycle. wr_ptr and memory are kept, so a partial trace stays readable.
- abort and start in the same cycle: abort wins.
- start while in ARMED or CAPTURE: ignored.
- busy and done are registered, decoded from the next state so they align with the state register.
- rd_data = mem[rd_addr] registered. A read of the address being written in the same cycle returns the old word.
- Reset asserted mid-capture: immediate return to IDLE, all outputs at reset values.

Optional Feature:
- Macro RO_TRACE_DECIM_EN.
- When defined:
  - Adds input port decim [7:0].
  - In CAPTURE, only every (decim+1)-th sum_valid is stored.
  - The decimation counter clears on entry to CAPTURE, so the first sample after the trigger is always stored.
  - decim=0 means no decimation.
- When undefined: no decim port; every sum_valid in CAPTURE is stored.

Test Plan:
- Basic capture:
  - Stimulus: N_RO=8, every count=0x0100, start, trig rise, 256 ro_valid pulses.
  - Required response: done=1, wr_ptr=256, every address reads 0x0800.
- Max-count sum:
  - Stimulus: all counts 0xFFFF.
  - Required response: every rd_data = 0x7FFF8 with no wrap (SUM_W=19).
- Trigger alignment:
  - Stimulus: ro_valid in the cycle of trig rise with count pattern i per sample.
  - Required response: mem[0] holds the following sample, not the coincident one.
- Abort mid-capture:
  - Stimulus: abort after 100 stored samples.
  - Required response: state IDLE, busy=0, done=0, wr_ptr=100, mem[0..99] intact.
- Re-arm from DONE:
  - Stimulus: start pulse.
  - Required response: done=0, busy=1, wr_ptr=0; a start+abort in the same cycle leaves the block in IDLE.
- Reset and decimation:
  - Stimulus: async reset pulse mid-capture.
  - Required response: all outputs 0 within the same cycle.
  - Stimulus (RO_TRACE_DECIM_EN): decim=3 with sample values 0..1023.
  - Required response: mem[k] = sum of sample 4k.

Source files
------------

// File: rtl/ro_trace_acq.sv
// ro_trace_acq: sums each RO count vector and captures a DEPTH-sample trace after a trigger edge.
// Define RO_TRACE_DECIM_EN to add the decim port and store only every (decim+1)-th sample.
module ro_trace_acq #(
  parameter int unsigned N_RO  = 8,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned SUM_W = CNT_W + $clog2(N_RO),
  parameter int unsigned DEPTH = 256
) (
  input  logic                       clock,
  input  logic                       reset,
`ifdef RO_TRACE_DECIM_EN
  input  logic [7:0]                 decim,
`endif
  input  logic                       start,
  input  logic                       abort,
  input  logic                       trig_in,
  input  logic                       ro_valid,
  input  logic [N_RO*CNT_W-1:0]      ro_counts,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [SUM_W-1:0]           rd_data,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     wr_ptr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] Full = DEPTH[AW:0];
  localparam logic [AW:0] One  = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

  state_e           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             sum_valid_q;
  logic             trig_q, trig_rise;
  logic             enter_q, enter_d;
  logic             busy_q, done_q;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [SUM_W-1:0] rd_data_q;
  logic [SUM_W-1:0] mem [DEPTH];
  logic             store_slot, store, dec_hit;

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < N_RO; k++) begin
      sum_d = sum_d + SUM_W'(ro_counts[k*CNT_W +: CNT_W]);
    end
  end

  assign trig_rise = trig_in & ~trig_q;

  // The first CAPTURE cycle carries the sample that coincided with the trigger; skip it.
  assign store_slot = (state_q == StCapture) && sum_valid_q && !enter_q && !abort;
  assign store      = store_slot && dec_hit;

`ifdef RO_TRACE_DECIM_EN
  logic [7:0] dec_cnt_q, dec_cnt_d;

  assign dec_hit = (dec_cnt_q == 8'd0);

  always_comb begin
    dec_cnt_d = dec_cnt_q;
    if (enter_d) begin
      dec_cnt_d = 8'd0;
    end else if (store_slot) begin
      dec_cnt_d = (dec_cnt_q >= decim) ? 8'd0 : dec_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dec_cnt_q <= 8'd0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
    end
  end
`else
  assign dec_hit = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    enter_d  = 1'b0;
    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d  = StArmed;
            wr_ptr_d = '0;
          end
        end
        StArmed: begin
          if (trig_rise) begin
            state_d = StCapture;
            enter_d = 1'b1;
          end
        end
        StCapture: begin
          if (store) begin
            wr_ptr_d = wr_ptr_q + One;
            if (wr_ptr_d == Full) state_d = StDone;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      enter_q     <= 1'b0;
      trig_q      <= 1'b0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d == StArmed) || (state_d == StCapture);
      done_q      <= (state_d == StDone);
      wr_ptr_q    <= wr_ptr_d;
      enter_q     <= enter_d;
      trig_q      <= trig_in;
      sum_valid_q <= ro_valid;
      if (ro_valid) sum_q <= sum_d;
      rd_data_q   <= mem[rd_addr];
    end
  end

  // Trace memory is intentionally not reset.
  always_ff @(posedge clock) begin
    if (store) mem[wr_ptr_q[AW-1:0]] <= sum_q;
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign wr_ptr  = wr_ptr_q;

endmodule

// File: tb/tb_ro_trace_acq.sv
// Self-checking bench for ro_trace_acq: control-sequence table plus randomized captures
// compared against a queue-based trace model.
module tb_ro_trace_acq;

  localparam int unsigned N_RO  = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SUM_W = 19;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic                  abort = 1'b0;
  logic                  trig_in = 1'b0;
  logic                  ro_valid = 1'b0;
  logic [N_RO*CNT_W-1:0] ro_counts = '0;
  logic [AW-1:0]         rd_addr = '0;
  logic [SUM_W-1:0]      rd_data;
  logic                  busy;
  logic                  done;
  logic [AW:0]           wr_ptr;
`ifdef RO_TRACE_DECIM_EN
  logic [7:0]            decim = 8'd0;
`endif

  int          errors = 0;
  int          checks = 0;
  int unsigned dec_n = 0;
  bit          trig_active = 1'b0;
  int unsigned n_after = 0;
  int unsigned exp_q[$];

  typedef struct {
    logic        st;
    logic        ab;
    logic        tr;
    logic        rv;
    logic [15:0] cnt;
    logic        eb;
    logic        ed;
    int unsigned ew;
  } vec_t;

  vec_t tbl[12];

  ro_trace_acq #(
    .N_RO (N_RO),
    .CNT_W(CNT_W),
    .SUM_W(SUM_W),
    .DEPTH(DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
`ifdef RO_TRACE_DECIM_EN
    .decim    (decim),
`endif
    .start    (start),
    .abort    (abort),
    .trig_in  (trig_in),
    .ro_valid (ro_valid),
    .ro_counts(ro_counts),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .wr_ptr   (wr_ptr)
  );

  always #5 clock = ~clock;

  function automatic int unsigned model_sum(input logic [N_RO*CNT_W-1:0] v);
    int unsigned s = 0;
    for (int k = 0; k < N_RO; k++) s += 32'(v[k*CNT_W +: CNT_W]);
    return s;
  endfunction

  function automatic logic [N_RO*CNT_W-1:0] gen(input int mode, input int unsigned i);
    logic [N_RO*CNT_W-1:0] v;
    for (int k = 0; k < N_RO; k++) begin
      case (mode)
        0:       v[k*CNT_W +: CNT_W] = 16'h0100;
        1:       v[k*CNT_W +: CNT_W] = 16'hFFFF;
        3:       v[k*CNT_W +: CNT_W] = 16'(i);
        default: v[k*CNT_W +: CNT_W] = 16'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    start    = 1'b0;
    abort    = 1'b0;
    ro_valid = 1'b0;
  endtask

  // Samples after the trigger cycle are kept, decimated, up to DEPTH of them.
  task automatic send(input logic [N_RO*CNT_W-1:0] v);
    ro_counts = v;
    ro_valid  = 1'b1;
    if (trig_active) begin
      if ((n_after % (dec_n + 1)) == 0 && exp_q.size() < DEPTH) exp_q.push_back(model_sum(v));
      n_after++;
      trig_in = 1'($urandom_range(0, 1));
    end
    cyc();
    repeat ($urandom_range(0, 2)) cyc();
  endtask

  task automatic arm();
    trig_in = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    chk("arm_busy", busy, 1);
    chk("arm_done", done, 0);
    chk("arm_wr_ptr", wr_ptr, 0);
    exp_q.delete();
    trig_active = 1'b0;
    n_after = 0;
  endtask

  task automatic fire();
    ro_counts = gen(2, 0);
    ro_valid  = 1'b1;
    trig_in   = 1'b1;
    cyc();
    trig_active = 1'b1;
  endtask

  task automatic readback(input string tag);
    for (int a = 0; a < exp_q.size(); a++) begin
      rd_addr = AW'(a);
      cyc();
      chk(tag, rd_data, exp_q[a]);
    end
  endtask

  task automatic run_capture(input string tag, input int mode, input int unsigned nsamp,
                             input int unsigned pre);
    arm();
    repeat (pre) send(gen(2, 0));
    fire();
    for (int unsigned i = 0; i < nsamp; i++) send(gen(mode, i));
    cyc();
    cyc();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wr_ptr"}, wr_ptr, DEPTH);
    readback(tag);
  endtask

  initial begin
    //          st    ab    tr    rv    cnt       busy  done  wr_ptr
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 256};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0011, 1'b1, 1'b0, 0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0022, 1'b1, 1'b0, 0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1};

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_ptr", wr_ptr, 0);
    chk("rst_rd_data", rd_data, 0);
    reset = 1'b0;
    cyc();

    run_capture("basic", 0, 256, 2);

    // Control sequencing from DONE, including the trigger-coincident sample
    trig_in = 1'b0;
    cyc();
    for (int i = 0; i < 12; i++) begin
      start     = tbl[i].st;
      abort     = tbl[i].ab;
      trig_in   = tbl[i].tr;
      ro_valid  = tbl[i].rv;
      ro_counts = {N_RO{tbl[i].cnt}};
      cyc();
      chk("tbl_busy", busy, tbl[i].eb);
      chk("tbl_done", done, tbl[i].ed);
      chk("tbl_wr_ptr", wr_ptr, tbl[i].ew);
    end
    rd_addr = '0;
    cyc();
    chk("trig_align", rd_data, 32'h110);

    run_capture("maxcnt", 1, 256, 0);
    run_capture("random", 2, 256, 3);

    // Abort after 100 stored samples keeps the partial trace
    arm();
    fire();
    for (int unsigned i = 0; i < 100; i++) send(gen(2, i));
    cyc();
    cyc();
    chk("abort_pre_wr_ptr", wr_ptr, 100);
    chk("abort_pre_busy", busy, 1);
    abort = 1'b1;
    cyc();
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_wr_ptr", wr_ptr, 100);
    cyc();
    chk("abort_hold_wr_ptr", wr_ptr, 100);
    readback("abort_mem");

    // Asynchronous reset mid-capture
    arm();
    fire();
    for (int unsigned i = 0; i < 50; i++) send(gen(2, i));
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_wr_ptr", wr_ptr, 0);
    chk("arst_rd_data", rd_data, 0);
    cyc();
    reset = 1'b0;
    trig_in = 1'b0;
    cyc();
    cyc();
    chk("arst_after_busy", busy, 0);
    chk("arst_after_wr_ptr", wr_ptr, 0);

`ifdef RO_TRACE_DECIM_EN
    decim = 8'd3;
    dec_n = 3;
    run_capture("decim", 3, 1024, 2);
    decim = 8'd0;
    dec_n = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
